// File: rtl/bk_pkg.sv
// bk_pkg: shared constants and types for the nibble-serial Brent-Kung word
// sequencer.
//   SLICE_W - width of one time-multiplexed adder slice (4 bits)
//   state_t - sequencer FSM states (IDLE, RUN, DONE)
package bk_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bk_nibble_add.sv
// bk_nibble_add: combinational 4-bit Brent-Kung prefix adder.
// Ports:
//   a, b  [3:0] in  - operand nibbles
//   cin         in  - carry into bit 0
//   sum   [3:0] out - a + b + cin, low 4 bits
//   cout        out - carry out of bit 3
module bk_nibble_add
    import bk_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               g0c;   // bit-0 generate with cin folded in
    logic               g10;   // group generate [1:0]
    logic               g32;   // group generate [3:2]
    logic               p32;   // group propagate [3:2]
    logic               g20;   // group generate [2:0]
    logic               g30;   // group generate [3:0]
    logic [SLICE_W-1:0] c;

    always_comb begin
        g   = a & b;
        p   = a ^ b;
        g0c = g[0] | (p[0] & cin);
        // up-sweep
        g10 = g[1] | (p[1] & g0c);
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        g30 = g32 | (p32 & g10);
        // down-sweep fills the odd-span prefix
        g20 = g[2] | (p[2] & g10);
        c    = {g20, g10, g0c, cin};
        sum  = p ^ c;
        cout = g30;
    end

endmodule

// File: rtl/bk_word_sequencer.sv
// bk_word_sequencer: WIDTH-bit adder that ripples one nibble per cycle through
// a single shared bk_nibble_add slice.
// Optional feature: define BK_SEQ_SUB_EN to add the in_sub port (subtract as
// A + ~B + 1; out_cout=1 means no borrow).
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin   - operands and carry-in
//   in_sub               - subtract request (BK_SEQ_SUB_EN only)
//   out_valid/out_ready  - result handshake (valid only in DONE)
//   out_sum, out_cout    - result word and final carry
//   busy                 - high outside IDLE
module bk_word_sequencer
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef BK_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [SLICE_W-1:0] nib_a;
    logic [SLICE_W-1:0] nib_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;
    logic               last_slice;

    assign accept     = (state_q == ST_IDLE) && in_valid;
    assign last_slice = (idx_q == IDX_LAST);

    // Slice operand mux: pick nibble idx of the latched operands.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*SLICE_W +: SLICE_W];
                nib_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    bk_nibble_add u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_slice) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = in_a;
            idx_d   = '0;
`ifdef BK_SEQ_SUB_EN
            b_d     = in_sub ? ~in_b : in_b;
            carry_d = in_sub ? 1'b1 : in_cin;
`else
            b_d     = in_b;
            carry_d = in_cin;
`endif
        end else if (state_q == ST_RUN) begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
                end
            end
            carry_d = slice_cout;
            if (last_slice) begin
                cout_d = slice_cout;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_sum   = sum_q;
        out_cout  = cout_q;
    end

endmodule

// File: tb/tb_bk_word_sequencer.sv
module tb_bk_word_sequencer;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned TMO    = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // results captured by run_op
    logic [WIDTH-1:0] got_sum;
    logic             got_cout;
    int               got_lat;

    always #5 clk = ~clk;

    bk_word_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef BK_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Reference: whole-word arithmetic, carry out is bit WIDTH.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin,
                                               input logic sub);
        logic [WIDTH:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        return r;
    endfunction

    // Drive one operation, wait for the result (bounded), then consume it.
    // got_lat = cycles after the accept edge until out_valid; -1 on timeout.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input bit consume);
        int n;
        n = 0;
        while (!in_ready && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        got_lat  = out_valid ? n : -1;
        got_sum  = out_sum;
        got_cout = out_cout;
        if (consume && out_valid) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({in_ready, out_valid, busy, out_cout, out_sum} !== {3'b100, 1'b0, {WIDTH{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want rdy=1 vld=0 busy=0 cout=0 sum=0",
                     in_ready, out_valid, busy, out_cout, out_sum);
        end
        #3 rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [WIDTH:0] exp;
        // first accept right after reset release
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        exp = ref_add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        n_tests++;
        if (got_lat !== NSLICE) begin
            n_fail++;
            $display("FAIL latency: got %0d want %0d", got_lat, NSLICE);
        end
        n_tests++;
        if ({got_cout, got_sum} !== exp || exp !== 17'h1_0000) begin
            n_fail++;
            $display("FAIL ffff_plus_1: got cout=%b sum=%h want cout=1 sum=0000", got_cout, got_sum);
        end
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if ({got_cout, got_sum} !== 17'h0_5556) begin
            n_fail++;
            $display("FAIL 1234_plus_4321_c1: got cout=%b sum=%h want cout=0 sum=5556", got_cout, got_sum);
        end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] s0;
        logic             c0;
        int               bad;
        run_op(16'h8001, 16'h8002, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({got_cout, got_sum} !== 17'h1_0003) begin
            n_fail++;
            $display("FAIL hold_value: got cout=%b sum=%h want cout=1 sum=0003", got_cout, got_sum);
        end
        s0 = got_sum; c0 = got_cout; bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_sum !== s0 || out_cout !== c0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d unstable cycles, want 0 (last vld=%b rdy=%b sum=%h)",
                     bad, out_valid, in_ready, out_sum);
        end
        // in_valid high during DONE handshake must not be accepted that cycle
        in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0101;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_to_idle: got rdy=%b vld=%b busy=%b want rdy=1 vld=0 busy=0",
                     in_ready, out_valid, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;    // idx now 2
        rst = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, busy, out_valid, out_cout, out_sum} !== {3'b100, 1'b0, {WIDTH{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid_run: got rdy=%b busy=%b vld=%b cout=%b sum=%h want rdy=1 busy=0 vld=0 cout=0 sum=0",
                     in_ready, busy, out_valid, out_cout, out_sum);
        end
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL no_result_after_reset: %0d active cycles, want 0", seen);
        end
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({got_cout, got_sum} !== 17'h0_0005) begin
            n_fail++;
            $display("FAIL after_reset_op: got cout=%b sum=%h want cout=0 sum=0005", got_cout, got_sum);
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        in_a = 16'h1357; in_b = 16'h2468; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0;   // stays asserted while busy
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        n_tests++;
        if (!out_valid || {out_cout, out_sum} !== 17'h0_37C0) begin
            n_fail++;
            $display("FAIL ignore_busy: got vld=%b cout=%b sum=%h want vld=1 cout=0 sum=37c0",
                     out_valid, out_cout, out_sum);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

`ifdef BK_SEQ_SUB_EN
    task automatic test_sub();
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if ({got_cout, got_sum} !== 17'h0_FFFE) begin
            n_fail++;
            $display("FAIL sub_5_7: got cout=%b sum=%h want cout=0 sum=fffe", got_cout, got_sum);
        end
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if ({got_cout, got_sum} !== 17'h1_0002) begin
            n_fail++;
            $display("FAIL sub_7_5: got cout=%b sum=%h want cout=1 sum=0002", got_cout, got_sum);
        end
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic             cin, sub;
        logic [WIDTH:0]   exp;
        for (int k = 0; k < 40; k++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
`ifdef BK_SEQ_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            if (k == 0) begin a = '1; b = '1; cin = 1'b1; end
            if (k == 1) begin a = '0; b = '0; cin = 1'b0; end
            exp = ref_add(a, b, cin, sub);
            run_op(a, b, cin, sub, 1'b1);
            n_tests++;
            if (got_lat !== NSLICE || {got_cout, got_sum} !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h",
                         k, a, b, cin, sub, got_lat, got_cout, got_sum, NSLICE, exp[WIDTH], exp[WIDTH-1:0]);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_run();
        test_ignore_busy();
`ifdef BK_SEQ_SUB_EN
        test_sub();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
